// File: rtl/fa_serial_driver.sv
// Bit-serial operand sequencer for an external full adder.
// Latches A, B and carry-in on an accepted start, presents one bit pair per step (LSB first)
// together with the running carry, waits SETTLE_CYCLES for the adder to settle, samples sum and
// carry-out, and assembles the WIDTH-bit result plus final carry.
// Optional build macro SERIAL_ADD_CHECK_EN adds a golden A+B+cin comparison that raises chk_err_o
// when the serially assembled result disagrees; without it chk_err_o is tied low.
module fa_serial_driver #(
    parameter int unsigned WIDTH         = 8,
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic             fa_a_o,
    output logic             fa_b_o,
    output logic             fa_cin_o,
    input  logic             fa_sum_i,
    input  logic             fa_cout_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o,
    output logic             chk_err_o
);

    localparam int unsigned CntW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned WaitW = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
    localparam logic [CntW-1:0]  LastBit  = CntW'(WIDTH - 1);
    localparam logic [WaitW-1:0] WaitInit = WaitW'(SETTLE_CYCLES);

    typedef enum logic [1:0] {
        StIdle,
        StEval,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_sh_q, a_sh_d;
    logic [WIDTH-1:0]  b_sh_q, b_sh_d;
    logic [WIDTH-1:0]  s_sh_q, s_sh_d;
    logic              carry_q, carry_d;
    logic [CntW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [WaitW-1:0]  wait_cnt_q, wait_cnt_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic              cout_q, cout_d;
    logic              done_q, done_d;

    // Next-state logic: everything holds while ena_i is low.
    always_comb begin
        state_d    = state_q;
        a_sh_d     = a_sh_q;
        b_sh_d     = b_sh_q;
        s_sh_d     = s_sh_q;
        carry_d    = carry_q;
        bit_cnt_d  = bit_cnt_q;
        wait_cnt_d = wait_cnt_q;
        sum_d      = sum_q;
        cout_d     = cout_q;
        done_d     = done_q;

        if (ena_i) begin
            done_d = 1'b0;
            unique case (state_q)
                StIdle, StDone: begin
                    // Publish the finished result; done_o follows one cycle later as a pulse.
                    if (state_q == StDone) begin
                        sum_d  = s_sh_q;
                        cout_d = carry_q;
                        done_d = 1'b1;
                    end
                    state_d = StIdle;
                    if (start_i) begin
                        a_sh_d     = a_i;
                        b_sh_d     = b_i;
                        carry_d    = cin_i;
                        bit_cnt_d  = '0;
                        wait_cnt_d = WaitInit;
                        state_d    = StEval;
                    end
                end
                StEval: begin
                    if (wait_cnt_q != '0) begin
                        wait_cnt_d = wait_cnt_q - WaitW'(1);
                    end else begin
                        s_sh_d     = {fa_sum_i, s_sh_q[WIDTH-1:1]};
                        carry_d    = fa_cout_i;
                        a_sh_d     = a_sh_q >> 1;
                        b_sh_d     = b_sh_q >> 1;
                        bit_cnt_d  = bit_cnt_q + CntW'(1);
                        wait_cnt_d = WaitInit;
                        if (bit_cnt_q == LastBit) begin
                            state_d = StDone;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            a_sh_q     <= '0;
            b_sh_q     <= '0;
            s_sh_q     <= '0;
            carry_q    <= 1'b0;
            bit_cnt_q  <= '0;
            wait_cnt_q <= '0;
            sum_q      <= '0;
            cout_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_sh_q     <= a_sh_d;
            b_sh_q     <= b_sh_d;
            s_sh_q     <= s_sh_d;
            carry_q    <= carry_d;
            bit_cnt_q  <= bit_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            sum_q      <= sum_d;
            cout_q     <= cout_d;
            done_q     <= done_d;
        end
    end

    // Adder drive comes straight from registers and is forced low outside evaluation.
    always_comb begin
        fa_a_o   = 1'b0;
        fa_b_o   = 1'b0;
        fa_cin_o = 1'b0;
        if (state_q == StEval) begin
            fa_a_o   = a_sh_q[0];
            fa_b_o   = b_sh_q[0];
            fa_cin_o = carry_q;
        end
    end

    assign busy_o = (state_q == StEval);
    assign done_o = done_q;
    assign sum_o  = sum_q;
    assign cout_o = cout_q;

`ifdef SERIAL_ADD_CHECK_EN
    logic [WIDTH:0] golden_q, golden_d;
    logic           chk_q, chk_d;
    logic           accept;

    assign accept = ena_i && start_i && (state_q != StEval);

    // Golden sum captured on accept; verdict taken when the result is published.
    // A back-to-back accept in the publishing cycle keeps the verdict of the op just finished.
    always_comb begin
        golden_d = golden_q;
        chk_d    = chk_q;
        if (accept) begin
            golden_d = (WIDTH+1)'(a_i) + (WIDTH+1)'(b_i) + (WIDTH+1)'(cin_i);
            chk_d    = 1'b0;
        end
        if (ena_i && (state_q == StDone)) begin
            chk_d = ({carry_q, s_sh_q} != golden_q);
        end
    end

    // Checker registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            golden_q <= '0;
            chk_q    <= 1'b0;
        end else begin
            golden_q <= golden_d;
            chk_q    <= chk_d;
        end
    end

    assign chk_err_o = chk_q;
`else
    assign chk_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_fa_serial_driver.sv
// Bench for fa_serial_driver: two instances (settle 1 and settle 3) each closed around a
// behavioural full adder that returns wrong values until its inputs have been stable long
// enough, so early sampling corrupts results. Expected results are plain A+B+cin arithmetic;
// expected latency is WIDTH*(S+1)+1 plus any cycles spent with ena low.
module tb_fa_serial_driver;

    localparam int W  = 8;
    localparam int S1 = 1;
    localparam int S2 = 3;
    localparam int LatLimit = 200;
`ifdef SERIAL_ADD_CHECK_EN
    localparam logic ChkOn = 1'b1;
`else
    localparam logic ChkOn = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n, ena, start1, start2, cin, stuck, watch, sel;
    logic [W-1:0] a_in, b_in;

    logic fa_a1, fa_b1, fa_cin1, fa_sum1, fa_cout1, busy1, done1, cout1, chk1;
    logic fa_a2, fa_b2, fa_cin2, fa_sum2, fa_cout2, busy2, done2, cout2, chk2;
    logic [W-1:0] sum1, sum2;

    int n_chk = 0;
    int n_bad = 0;
    int age1 = 100, age2 = 100;
    logic [2:0] prev1 = '0, prev2 = '0;
    int idle_err = 0, cin_err = 0, cin_seen = 0;

    always #5 clk = ~clk;

    fa_serial_driver #(.WIDTH(W), .SETTLE_CYCLES(S1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .ena_i(ena), .start_i(start1), .a_i(a_in), .b_i(b_in),
        .cin_i(cin), .fa_a_o(fa_a1), .fa_b_o(fa_b1), .fa_cin_o(fa_cin1), .fa_sum_i(fa_sum1),
        .fa_cout_i(fa_cout1), .busy_o(busy1), .done_o(done1), .sum_o(sum1), .cout_o(cout1),
        .chk_err_o(chk1)
    );

    fa_serial_driver #(.WIDTH(W), .SETTLE_CYCLES(S2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .ena_i(ena), .start_i(start2), .a_i(a_in), .b_i(b_in),
        .cin_i(cin), .fa_a_o(fa_a2), .fa_b_o(fa_b2), .fa_cin_o(fa_cin2), .fa_sum_i(fa_sum2),
        .fa_cout_i(fa_cout2), .busy_o(busy2), .done_o(done2), .sum_o(sum2), .cout_o(cout2),
        .chk_err_o(chk2)
    );

    // Full-adder models: output is inverted until inputs have been steady for S cycles.
    always @(negedge clk) begin
        age1  <= ({fa_a1, fa_b1, fa_cin1} != prev1) ? 0 : ((age1 < 100) ? age1 + 1 : age1);
        age2  <= ({fa_a2, fa_b2, fa_cin2} != prev2) ? 0 : ((age2 < 100) ? age2 + 1 : age2);
        prev1 <= {fa_a1, fa_b1, fa_cin1};
        prev2 <= {fa_a2, fa_b2, fa_cin2};
    end

    logic bad1, bad2;
    assign bad1     = (age1 < S1);
    assign bad2     = (age2 < S2);
    assign fa_sum1  = stuck ? 1'b0 : (fa_a1 ^ fa_b1 ^ fa_cin1 ^ bad1);
    assign fa_cout1 = ((fa_a1 & fa_b1) | (fa_a1 & fa_cin1) | (fa_b1 & fa_cin1)) ^ bad1;
    assign fa_sum2  = fa_a2 ^ fa_b2 ^ fa_cin2 ^ bad2;
    assign fa_cout2 = ((fa_a2 & fa_b2) | (fa_a2 & fa_cin2) | (fa_b2 & fa_cin2)) ^ bad2;

    // Adder drive must be idle outside evaluation; carry trace watched during the wrap case.
    always @(negedge clk) begin
        if (rst_n) begin
            if (!busy1 && (fa_a1 || fa_b1 || fa_cin1)) idle_err <= idle_err + 1;
            if (!busy2 && (fa_a2 || fa_b2 || fa_cin2)) idle_err <= idle_err + 1;
            if (watch && busy1) begin
                cin_seen <= cin_seen + 1;
                if (!fa_cin1) cin_err <= cin_err + 1;
            end
        end
    end

    logic busy_s, done_s, cout_s, chk_s;
    logic [W-1:0] sum_s;
    assign busy_s = sel ? busy2 : busy1;
    assign done_s = sel ? done2 : done1;
    assign cout_s = sel ? cout2 : cout1;
    assign chk_s  = sel ? chk2 : chk1;
    assign sum_s  = sel ? sum2 : sum1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One operation on the selected instance, optionally stalling ena for stall_len cycles.
    task automatic run_op(input logic use2, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic c, input logic [W:0] exp, input logic exp_chk,
                          input int stall_at, input int stall_len, input string tag);
        int lat;
        int exp_lat;
        sel = use2;
        @(negedge clk);
        a_in = a; b_in = b; cin = c;
        if (use2) start2 = 1'b1; else start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0; start2 = 1'b0;
        check_eq({tag, " busy"}, 32'(busy_s), 32'd1);
        lat = 0;
        while (!done_s && lat < LatLimit) begin
            if (stall_len > 0 && lat == stall_at) begin
                ena = 1'b0;
                repeat (stall_len) begin @(posedge clk); #1 lat++; end
                ena = 1'b1;
            end
            @(posedge clk); #1 lat++;
        end
        exp_lat = W * ((use2 ? S2 : S1) + 1) + 1 + stall_len;
        check_eq({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check_eq({tag, " sum"}, 32'(sum_s), 32'(exp[W-1:0]));
        check_eq({tag, " cout"}, 32'(cout_s), 32'(exp[W]));
        check_eq({tag, " chk_err"}, 32'(chk_s), 32'(exp_chk));
        check_eq({tag, " busy end"}, 32'(busy_s), 32'd0);
    endtask

    initial begin
        int lat;
        logic [W-1:0] ra, rb;
        logic rc;
        logic [W:0] rexp;
        rst_n = 1'b0; ena = 1'b1; start1 = 1'b0; start2 = 1'b0; cin = 1'b0;
        stuck = 1'b0; watch = 1'b0; sel = 1'b0; a_in = '0; b_in = '0;

        repeat (2) @(posedge clk);
        #1;
        check_eq("reset dut1", {fa_a1, fa_b1, fa_cin1, busy1, done1, cout1, chk1, sum1}, 0);
        check_eq("reset dut2", {fa_a2, fa_b2, fa_cin2, busy2, done2, cout2, chk2, sum2}, 0);
        @(negedge clk) rst_n = 1'b1;

        // Basic
        run_op(1'b0, 8'h35, 8'h4A, 1'b0, 9'h07F, 1'b0, 0, 0, "basic");

        // Reset mid-evaluation
        @(negedge clk);
        a_in = 8'hFF; b_in = 8'hFF; cin = 1'b1; start1 = 1'b1;
        @(posedge clk); #1 start1 = 1'b0;
        repeat (5) @(posedge clk);
        #1 check_eq("pre-reset fa_a", 32'(fa_a1), 32'd1);
        @(negedge clk) rst_n = 1'b0;
        #1 check_eq("mid reset", {fa_a1, fa_b1, fa_cin1, busy1, done1, cout1, chk1, sum1}, 0);
        @(negedge clk) rst_n = 1'b1;
        run_op(1'b0, 8'h5A, 8'h0F, 1'b1, 9'h06A, 1'b0, 0, 0, "after reset");

        // Wrap: carry stays high for every bit step
        watch = 1'b1;
        run_op(1'b0, 8'hFF, 8'h00, 1'b1, 9'h100, 1'b0, 0, 0, "wrap");
        watch = 1'b0;
        check_eq("wrap fa_cin low", 32'(cin_err), 32'd0);
        check_eq("wrap eval cycles", 32'(cin_seen), 32'(W * (S1 + 1)));

        // Ignored mid-op start, then back-to-back start in the done cycle
        sel = 1'b0;
        @(negedge clk);
        a_in = 8'h35; b_in = 8'h4A; cin = 1'b0; start1 = 1'b1;
        @(posedge clk); #1 start1 = 1'b0;
        lat = 0;
        while (!done1 && lat < LatLimit) begin
            if (lat == 4) begin a_in = 8'h77; b_in = 8'h77; cin = 1'b1; start1 = 1'b1; end
            @(posedge clk); #1 lat++;
            start1 = 1'b0;
        end
        check_eq("b2b first latency", 32'(lat), 32'd17);
        check_eq("b2b first sum", 32'({cout1, sum1}), 32'h07F);
        a_in = 8'h01; b_in = 8'h01; cin = 1'b1; start1 = 1'b1;
        @(posedge clk); #1 start1 = 1'b0;
        check_eq("done pulse width", 32'(done1), 32'd0);
        check_eq("b2b accepted", 32'(busy1), 32'd1);
        check_eq("sum held", 32'(sum1), 32'h7F);
        lat = 0;
        while (!done1 && lat < LatLimit) begin @(posedge clk); #1 lat++; end
        check_eq("b2b second latency", 32'(lat), 32'd17);
        check_eq("b2b second sum", 32'({cout1, sum1}), 32'h003);

        // Settle 3 with and without an ena stall; done holds while ena is low
        run_op(1'b1, 8'h12, 8'h34, 1'b1, 9'h047, 1'b0, 0, 0, "settle3");
        run_op(1'b1, 8'hC3, 8'h5D, 1'b0, 9'h120, 1'b0, 10, 5, "settle3 stall");
        ena = 1'b0;
        repeat (3) @(posedge clk);
        #1 check_eq("done held ena low", 32'(done2), 32'd1);
        ena = 1'b1;
        @(posedge clk);
        #1 check_eq("done clears ena high", 32'(done2), 32'd0);

        // Stuck-at sum fault: only the checked build flags it
        stuck = 1'b1;
        run_op(1'b0, 8'h04, 8'h00, 1'b0, 9'h000, ChkOn, 0, 0, "stuck sum");
        stuck = 1'b0;
        repeat (3) @(posedge clk);
        #1 check_eq("chk_err sticky", 32'(chk1), 32'(ChkOn));
        run_op(1'b0, 8'h10, 8'h20, 1'b0, 9'h030, 1'b0, 0, 0, "chk cleared");

        // Randomized operations against plain arithmetic
        for (int i = 0; i < 24; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
            rexp = (W+1)'(ra) + (W+1)'(rb) + (W+1)'(rc);
            run_op(1'((i % 4) == 3), ra, rb, rc, rexp, 1'b0, int'($urandom_range(1, 10)),
                   int'($urandom_range(0, 3)), $sformatf("rand%0d", i));
        end

        check_eq("idle fa drive", 32'(idle_err), 32'd0);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
